// File: rtl/ir_nec_pkg.sv
// Shared types and NEC timing windows (in 10 us ticks) for the IR video-mode selector.
package ir_nec_pkg;

  localparam int WCNT_W = 11;
  typedef logic [WCNT_W-1:0] width_t;
  typedef logic [3:0]        mode_t;

  localparam width_t LEAD_LO_MIN = 11'd800;
  localparam width_t LEAD_LO_MAX = 11'd1000;
  localparam width_t LEAD_HI_MIN = 11'd400;
  localparam width_t LEAD_HI_MAX = 11'd500;
  localparam width_t RPT_HI_MIN  = 11'd200;
  localparam width_t RPT_HI_MAX  = 11'd250;
  localparam width_t BIT_MIN     = 11'd40;
  localparam width_t BIT_MAX     = 11'd70;
  localparam width_t ONE_MIN     = 11'd140;
  localparam width_t ONE_MAX     = 11'd190;
  localparam width_t WIDTH_MAX   = 11'd2047;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_LOW,
    LEAD_HIGH,
    BIT_LOW,
    BIT_HIGH,
    STOP,
    RPT_STOP,
    CHECK
  } nec_state_e;

  function automatic logic in_win(width_t w, width_t lo, width_t hi);
    return (w >= lo) && (w <= hi);
  endfunction

endpackage

// File: rtl/ir_vid_mode_sel_if.sv
// IR input and decoded key/mode outputs of the video-mode selector.
interface ir_vid_mode_sel_if;
  logic       i_ir;
  logic [3:0] o_vid_mode;
  logic       o_key_valid;
  logic [7:0] o_key_code;
  logic       o_key_repeat;
  logic       o_frame_err;

  modport slave (
    input  i_ir,
    output o_vid_mode, o_key_valid, o_key_code, o_key_repeat, o_frame_err
  );

  modport master (
    output i_ir,
    input  o_vid_mode, o_key_valid, o_key_code, o_key_repeat, o_frame_err
  );
endinterface

// File: rtl/ir_nec_rx.sv
// NEC IR receiver: synchronizer, glitch filter, 10 us tick, pulse-width FSM and
// inverse-byte checks. All outputs are single-clock pulses except addr/cmd.
module ir_nec_rx
  import ir_nec_pkg::*;
#(
  parameter int CLK_HZ   = 50000000,
  parameter int FILT_LEN = 4
) (
  input  logic       i_local_clk,
  input  logic       i_rst_n,
  input  logic       i_ir,
  output logic       frame_valid,
  output logic [7:0] addr,
  output logic [7:0] cmd,
  output logic       rpt,
  output logic       err
);

  localparam int DIV   = (CLK_HZ / 100000 < 1) ? 1 : CLK_HZ / 100000;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FC_W  = $clog2(FILT_LEN + 1);

  logic [1:0]       sync_q;
  logic             filt_q, filt_d1;
  logic [FC_W-1:0]  fcnt_q;
  logic [DIV_W-1:0] div_q;
  logic             tick, fall, rise, any_edge, timeout;
  width_t           width_q;

  nec_state_e  state_q, state_d;
  logic [31:0] sr_q, sr_d;
  logic [4:0]  bcnt_q, bcnt_d;

  assign tick     = (div_q == DIV_W'(DIV - 1));
  assign fall     = filt_d1 & ~filt_q;
  assign rise     = ~filt_d1 & filt_q;
  assign any_edge = fall | rise;

  assign addr = sr_q[7:0];
  assign cmd  = sr_q[23:16];

  always_ff @(posedge i_local_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q  <= '1;
      filt_q  <= 1'b1;
      filt_d1 <= 1'b1;
      fcnt_q  <= '0;
      div_q   <= '0;
      width_q <= '0;
    end else begin
      sync_q  <= {sync_q[0], i_ir};
      filt_d1 <= filt_q;
      // Level flips only after FILT_LEN consecutive samples disagree with it.
      if (sync_q[1] == filt_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == FC_W'(FILT_LEN - 1)) begin
        filt_q <= sync_q[1];
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
      div_q <= tick ? '0 : div_q + 1'b1;
      if (any_edge) begin
        width_q <= '0;
      end else if (tick && (width_q != WIDTH_MAX)) begin
        width_q <= width_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_local_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign timeout = (state_q != IDLE) && (state_q != CHECK) && !any_edge &&
                   (width_q == WIDTH_MAX);

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bcnt_d      = bcnt_q;
    frame_valid = 1'b0;
    rpt         = 1'b0;
    err         = 1'b0;
    case (state_q)
      IDLE: if (fall) state_d = LEAD_LOW;
      LEAD_LOW: if (rise) begin
        if (in_win(width_q, LEAD_LO_MIN, LEAD_LO_MAX)) state_d = LEAD_HIGH;
        else err = 1'b1;
      end
      LEAD_HIGH: if (fall) begin
        if (in_win(width_q, LEAD_HI_MIN, LEAD_HI_MAX)) begin
          state_d = BIT_LOW;
          bcnt_d  = '0;
        end else if (in_win(width_q, RPT_HI_MIN, RPT_HI_MAX)) begin
          state_d = RPT_STOP;
        end else begin
          err = 1'b1;
        end
      end
      BIT_LOW: if (rise) begin
        if (in_win(width_q, BIT_MIN, BIT_MAX)) state_d = BIT_HIGH;
        else err = 1'b1;
      end
      BIT_HIGH: if (fall) begin
        if (in_win(width_q, BIT_MIN, BIT_MAX) || in_win(width_q, ONE_MIN, ONE_MAX)) begin
          sr_d    = {in_win(width_q, ONE_MIN, ONE_MAX), sr_q[31:1]};
          bcnt_d  = bcnt_q + 5'd1;
          state_d = (bcnt_q == 5'd31) ? STOP : BIT_LOW;
        end else begin
          err = 1'b1;
        end
      end
      STOP: if (rise) begin
        if (in_win(width_q, BIT_MIN, BIT_MAX)) state_d = CHECK;
        else err = 1'b1;
      end
      RPT_STOP: if (rise) begin
        if (in_win(width_q, BIT_MIN, BIT_MAX)) begin
          rpt     = 1'b1;
          state_d = IDLE;
        end else begin
          err = 1'b1;
        end
      end
      CHECK: begin
        if ((sr_q[31:24] == ~sr_q[23:16]) && (sr_q[15:8] == ~sr_q[7:0])) frame_valid = 1'b1;
        else err = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (timeout) err = 1'b1;
    if (err) state_d = IDLE;
  end

endmodule

// File: rtl/ir_vid_mode_sel.sv
// NEC IR remote to 4-bit video-mode index. Define IR_ADDR_CHECK_EN to also
// require the NEC address to equal IR_ADDR (mismatching frames dropped silently).
module ir_vid_mode_sel
  import ir_nec_pkg::*;
#(
  parameter int         CLK_HZ    = 50000000,
  parameter int         NUM_MODES = 16,
  parameter logic [7:0] KEY_UP    = 8'h18,
  parameter logic [7:0] KEY_DOWN  = 8'h52,
  parameter int         FILT_LEN  = 4,
  parameter logic [7:0] IR_ADDR   = 8'h00
) (
  input  logic               i_local_clk,
  input  logic               i_rst_n,
  ir_vid_mode_sel_if.slave   bus
);

  localparam logic [7:0] NUM_B     = 8'(NUM_MODES);
  localparam mode_t      MODE_LAST = 4'(NUM_MODES - 1);

  // A zero mask makes the address compare vacuous when the feature is off.
`ifdef IR_ADDR_CHECK_EN
  localparam logic [7:0] ADDR_MASK = 8'hFF;
`else
  localparam logic [7:0] ADDR_MASK = 8'h00;
`endif

  logic       frame_valid, rpt, err, accept;
  logic [7:0] addr, cmd;
  mode_t      mode_d;

  ir_nec_rx #(
    .CLK_HZ  (CLK_HZ),
    .FILT_LEN(FILT_LEN)
  ) u_rx (
    .i_local_clk(i_local_clk),
    .i_rst_n    (i_rst_n),
    .i_ir       (bus.i_ir),
    .frame_valid(frame_valid),
    .addr       (addr),
    .cmd        (cmd),
    .rpt        (rpt),
    .err        (err)
  );

  assign accept = frame_valid && (((addr ^ IR_ADDR) & ADDR_MASK) == '0);

  // Digits take priority, so KEY_UP/KEY_DOWN codes below NUM_MODES select directly.
  always_comb begin
    mode_d = bus.o_vid_mode;
    if (cmd < NUM_B) begin
      mode_d = cmd[3:0];
    end else if (cmd == KEY_UP) begin
      mode_d = (bus.o_vid_mode == MODE_LAST) ? '0 : bus.o_vid_mode + 4'd1;
    end else if (cmd == KEY_DOWN) begin
      mode_d = (bus.o_vid_mode == '0) ? MODE_LAST : bus.o_vid_mode - 4'd1;
    end
  end

  always_ff @(posedge i_local_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_vid_mode   <= '0;
      bus.o_key_valid  <= 1'b0;
      bus.o_key_code   <= '0;
      bus.o_key_repeat <= 1'b0;
      bus.o_frame_err  <= 1'b0;
    end else begin
      bus.o_key_valid  <= accept;
      bus.o_key_repeat <= rpt;
      bus.o_frame_err  <= err;
      if (accept) begin
        bus.o_key_code <= cmd;
        bus.o_vid_mode <= mode_d;
      end
    end
  end

endmodule

// File: tb/tb_ir_vid_mode_sel.sv
// Scoreboard bench for ir_vid_mode_sel: randomized NEC waveforms, expected events
// queued at stimulus time and popped by an independent output monitor.
module tb_ir_vid_mode_sel;

  localparam int NUM_MODES = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  typedef struct {
    int         kind;   // 1 key, 2 repeat, 3 error
    logic [7:0] code;
    logic [3:0] mode;
  } exp_t;

  exp_t       sb[$];
  int         model_mode = 0;
  logic [7:0] model_code = 8'h00;

  ir_vid_mode_sel_if bus();

  always #5 clk = ~clk;

  // CLK_HZ of 100 kHz gives one 10 us tick per clock, keeping frames short.
  ir_vid_mode_sel #(
    .CLK_HZ   (100000),
    .NUM_MODES(NUM_MODES),
    .KEY_UP   (8'h18),
    .KEY_DOWN (8'h52),
    .FILT_LEN (4),
    .IR_ADDR  (8'h00)
  ) dut (
    .i_local_clk(clk),
    .i_rst_n    (rst_n),
    .bus        (bus)
  );

  function automatic void check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endfunction

  function automatic int next_mode(int m, int c);
    if (c < NUM_MODES) return c;
    if (c == 8'h18)    return (m + 1) % NUM_MODES;
    if (c == 8'h52)    return (m + NUM_MODES - 1) % NUM_MODES;
    return m;
  endfunction

  function automatic void push(int kind);
    exp_t e;
    e.kind = kind;
    e.code = model_code;
    e.mode = 4'(model_mode);
    sb.push_back(e);
  endfunction

  task automatic seg(logic lvl, int n);
    bus.i_ir = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_word(logic [31:0] w, int nbits);
    seg(1'b0, int'($urandom_range(810, 880)));
    seg(1'b1, int'($urandom_range(415, 470)));
    for (int i = 0; i < nbits; i++) begin
      seg(1'b0, int'($urandom_range(45, 65)));
      seg(1'b1, w[i] ? int'($urandom_range(150, 180)) : int'($urandom_range(45, 65)));
    end
    seg(1'b0, int'($urandom_range(45, 65)));
    bus.i_ir = 1'b1;
  endtask

  task automatic settle(string name);
    int waited = 0;
    seg(1'b1, 20);
    while (sb.size() != 0 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    check({"drain_", name}, sb.size(), 0);
    sb.delete();
    seg(1'b1, 30);
  endtask

  task automatic frame(string name, logic [7:0] a, logic [7:0] c, logic [7:0] b1, logic [7:0] b3);
    bit ok_addr;
`ifdef IR_ADDR_CHECK_EN
    ok_addr = (a == 8'h00);
`else
    ok_addr = 1'b1;
`endif
    if (b1 == ~a && b3 == ~c) begin
      if (ok_addr) begin
        model_mode = next_mode(model_mode, int'(c));
        model_code = c;
        push(1);
      end
    end else begin
      push(3);
    end
    send_word({b3, c, b1, a}, 32);
    settle(name);
  endtask

  task automatic frame_ok(string name, logic [7:0] a, logic [7:0] c);
    frame(name, a, c, ~a, ~c);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_vid_mode"},   int'(bus.o_vid_mode),   0);
    check({tag, "_key_valid"},  int'(bus.o_key_valid),  0);
    check({tag, "_key_code"},   int'(bus.o_key_code),   0);
    check({tag, "_key_repeat"}, int'(bus.o_key_repeat), 0);
    check({tag, "_frame_err"},  int'(bus.o_frame_err),  0);
  endtask

  // Output monitor: every pulse must match the oldest queued expectation.
  initial begin
    int   kind;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (bus.o_key_valid || bus.o_key_repeat || bus.o_frame_err)) begin
        kind = bus.o_key_valid ? 1 : (bus.o_key_repeat ? 2 : 3);
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_event: got kind %0d expected none", kind);
        end else begin
          e = sb.pop_front();
          check("event_kind", kind, e.kind);
          check("pulse_onehot", int'(bus.o_key_valid) + int'(bus.o_key_repeat) +
                int'(bus.o_frame_err), 1);
          check("key_code", int'(bus.o_key_code), int'(e.code));
          check("vid_mode", int'(bus.o_vid_mode), int'(e.mode));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a, c, b3;
    bus.i_ir = 1'b1;
    rst_n    = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    seg(1'b1, 20);

    frame_ok("cmd05", 8'h00, 8'h05);

    // Reset in the middle of a frame, with the line low.
    seg(1'b0, 850);
    seg(1'b1, 440);
    for (int i = 0; i < 3; i++) begin
      seg(1'b0, 55);
      seg(1'b1, 160);
    end
    seg(1'b0, 30);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    bus.i_ir = 1'b1;
    repeat (5) @(negedge clk);
    rst_n      = 1'b1;
    model_mode = 0;
    model_code = 8'h00;
    check("midrst_queue", sb.size(), 0);
    seg(1'b1, 20);

    frame_ok("after_rst", 8'h00, 8'h05);
    frame_ok("cmd0F",     8'h00, 8'h0F);
    frame_ok("up_wrap",   8'h00, 8'h18);
    frame_ok("down_wrap", 8'h00, 8'h52);
    frame("bad_inv", 8'h00, 8'h05, 8'hFF, 8'hFB);

    push(3);
    seg(1'b0, 700);
    bus.i_ir = 1'b1;
    settle("short_lead");

    push(2);
    seg(1'b0, int'($urandom_range(850, 950)));
    seg(1'b1, int'($urandom_range(210, 240)));
    seg(1'b0, int'($urandom_range(45, 65)));
    bus.i_ir = 1'b1;
    settle("repeat");

    seg(1'b0, 2);
    seg(1'b1, 100);

    push(3);
    send_word({8'hFA, 8'h05, 8'hFF, 8'h00}, 10);
    settle("timeout");

    frame_ok("after_to", 8'h00, 8'h03);
    frame_ok("addr01",   8'h01, 8'h07);

    for (int i = 0; i < 2; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      case ($urandom_range(0, 3))
        0:       c = 8'($urandom_range(0, 15));
        1:       c = 8'h18;
        2:       c = 8'h52;
        default: c = 8'($urandom);
      endcase
      b3 = ($urandom_range(0, 3) == 0) ? (~c ^ 8'h20) : ~c;
      frame("rand", a, c, ~a, b3);
    end

    check("final_queue", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
